// File: rtl/fifo_byte_framer_if.sv
// Handshake bundle between the FIFO read port, the framer and the byte sink.
// The master modport is the framer; the slave modport is its environment.
interface fifo_byte_framer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ack;
    logic [7:0]            byte_out;
    logic                  byte_out_valid;
    logic                  byte_out_ready;
    logic                  byte_out_first;
    logic                  byte_out_last;

    modport master (
        input  data_in, data_in_valid, byte_out_ready,
        output data_in_ack, byte_out, byte_out_valid, byte_out_first, byte_out_last
    );

    modport slave (
        output data_in, data_in_valid, byte_out_ready,
        input  data_in_ack, byte_out, byte_out_valid, byte_out_first, byte_out_last
    );
endinterface

// File: rtl/fifo_byte_framer.sv
// Pops words from a FIFO read port and emits them as byte frames:
// SOF byte, PACKET_WORDS words MSB byte first, then an XOR checksum byte.
// All outputs except the FIFO pop strobe are registered.
module fifo_byte_framer #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          PACKET_WORDS = 4,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
    input  logic               clock_out,
    input  logic               rst_out_n,
    fifo_byte_framer_if.master bus,
    output logic [15:0]        packet_count
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_WORDS - 1);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, WAIT_WORD, CHECKSUM} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic [15:0]           packet_count_d;
    logic                  ack;
    logic                  handshake;
    logic                  last_byte;
    logic                  last_word;

    assign handshake = valid_q & bus.byte_out_ready;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign last_word = (word_cnt_q == LAST_CNT);

    // Byte idx of a word, counted from the most significant byte.
    function automatic logic [7:0] byte_of(input logic [DATA_WIDTH-1:0] w,
                                           input logic [IDX_W-1:0]      idx);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = w << (32'(idx) * 32'd8);
        return shifted[DATA_WIDTH-1 -: 8];
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clock_out or negedge rst_out_n) begin
        if (!rst_out_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Pop strobe: exactly one ack per word loaded into word_q, never during reset.
    always_comb begin
        ack = 1'b0;
        if (rst_out_n) begin
            case (state_q)
                IDLE, WAIT_WORD: ack = bus.data_in_valid;
                PAYLOAD:         ack = handshake & last_byte & ~last_word & bus.data_in_valid;
                CHECKSUM:        ack = handshake & bus.data_in_valid;
                default:         ack = 1'b0;
            endcase
        end
    end

    // Next-state and next-register values.
    // NOTE: every signal gets a hold default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        byte_idx_d     = byte_idx_q;
        word_cnt_d     = word_cnt_q;
        csum_d         = csum_q;
        byte_d         = byte_q;
        valid_d        = valid_q;
        first_d        = first_q;
        last_d         = last_q;
        packet_count_d = packet_count;

        case (state_q)
            HEADER: begin
                if (handshake) begin
                    byte_d  = byte_of(word_q, '0);
                    first_d = 1'b0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (handshake) begin
                    csum_d = csum_q ^ byte_q;
                    if (!last_byte) begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        byte_d     = byte_of(word_q, byte_idx_q + IDX_W'(1));
                    end else if (!last_word && bus.data_in_valid) begin
                        word_d     = bus.data_in;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        byte_idx_d = '0;
                        byte_d     = byte_of(bus.data_in, '0);
                    end else if (!last_word) begin
                        valid_d = 1'b0;
                        state_d = WAIT_WORD;
                    end else begin
                        byte_d  = csum_q ^ byte_q;
                        last_d  = 1'b1;
                        state_d = CHECKSUM;
                    end
                end
            end
            WAIT_WORD: begin
                if (ack) begin
                    word_d     = bus.data_in;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    byte_idx_d = '0;
                    byte_d     = byte_of(bus.data_in, '0);
                    valid_d    = 1'b1;
                    state_d    = PAYLOAD;
                end
            end
            CHECKSUM: begin
                if (handshake) begin
                    packet_count_d = packet_count + 16'd1;
                    valid_d        = 1'b0;
                    last_d         = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: ;
        endcase

        // A new frame starts from IDLE, or straight after the checksum is taken.
        if (ack && (state_q == IDLE || state_q == CHECKSUM)) begin
            word_d     = bus.data_in;
            word_cnt_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            byte_d     = SOF_BYTE;
            valid_d    = 1'b1;
            first_d    = 1'b1;
            last_d     = 1'b0;
            state_d    = HEADER;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock_out or negedge rst_out_n) begin
        if (!rst_out_n) begin
            word_q       <= '0;
            byte_idx_q   <= '0;
            word_cnt_q   <= '0;
            csum_q       <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            packet_count <= '0;
        end else begin
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            word_cnt_q   <= word_cnt_d;
            csum_q       <= csum_d;
            byte_q       <= byte_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            packet_count <= packet_count_d;
        end
    end

    assign bus.data_in_ack    = ack;
    assign bus.byte_out       = byte_q;
    assign bus.byte_out_valid = valid_q;
    assign bus.byte_out_first = first_q;
    assign bus.byte_out_last  = last_q;
endmodule
